// File: rtl/frame_writer.sv
// Frame writer: drains a filtered-pixel FIFO into an image RAM, one full
// ROW x COL frame per start request, raster order, one pixel per cycle max.
module frame_writer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ROW        = 256,
    parameter int COL        = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  pop,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0]   TOTAL    = (ADDR_WIDTH+1)'(ROW * COL);
    localparam logic [ADDR_WIDTH-1:0] COL_W    = ADDR_WIDTH'(COL);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(COL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   pop_cnt;
    logic [ADDR_WIDTH-1:0] row, col;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    // pop is gated by reset so no pixel leaves the FIFO while the frame is being aborted
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                pop = reset && !fifo_empty && (pop_cnt < TOTAL);
                if (pop && (pop_cnt == TOTAL - 1'b1)) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            pop_cnt    <= '0;
            row        <= '0;
            col        <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state    <= state_nxt;
            mem_we_q <= pop;
            if (state == IDLE && start) begin
                pop_cnt <= '0;
                row     <= '0;
                col     <= '0;
            end else if (pop) begin
                pop_cnt    <= pop_cnt + 1'b1;
                mem_addr_q <= row * COL_W + col;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // FIFO read data only becomes valid the cycle after pop, which is the
    // write cycle itself, so data is passed straight through under mem_we.
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_we_q ? fifo_data : '0;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == FIN);

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer (ROW=2, COL=3): FIFO model, frame-level
// reference model compared every cycle, plus directed literal checks.
module tb_frame_writer;
    localparam int AW = 16, DW = 8, ROW = 2, COL = 3, N = ROW * COL;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          pop, mem_we, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    always #5 clk = ~clk;

    frame_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW(ROW), .COL(COL)) dut (
        .clk(clk), .reset(reset), .start(start), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .pop(pop), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .done(done)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    byte unsigned fifo_q[$];
    bit  force_empty = 1'b0;

    // frame-level model: 0 idle, 1 writing frame, 2 last write, 3 done pulse
    int           m_mode = 0, m_pops = 0, m_wr_addr = 0;
    bit           m_wr = 1'b0;
    byte unsigned m_wr_data = 0;

    int           wr_addr_log[$], wr_cyc_log[$], done_cyc_log[$], pop_cyc_log[$];
    byte unsigned wr_data_log[$];
    int           dut_pops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
        done_cyc_log.delete(); pop_cyc_log.delete(); dut_pops = 0;
    endtask

    task automatic step();
        bit exp_pop, popped;
        fifo_empty = force_empty || (fifo_q.size() == 0);
        @(negedge clk);
        exp_pop = (m_mode == 1) && reset && !fifo_empty && (m_pops < N);
        chk("pop",    32'(pop),    32'(exp_pop));
        chk("mem_we", 32'(mem_we), 32'(m_wr));
        chk("busy",   32'(busy),   32'(m_mode == 1 || m_mode == 2));
        chk("done",   32'(done),   32'(m_mode == 3));
        if (m_wr) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_wr_addr));
            chk("mem_data", 32'(mem_data), 32'(m_wr_data));
        end
        if (mem_we) begin
            wr_addr_log.push_back(int'(mem_addr));
            wr_data_log.push_back(mem_data);
            wr_cyc_log.push_back(cyc);
        end
        if (done) done_cyc_log.push_back(cyc);
        if (pop) begin dut_pops++; pop_cyc_log.push_back(cyc); end
        popped = pop;
        if (!reset) begin
            m_mode = 0; m_pops = 0; m_wr = 1'b0;
        end else begin
            m_wr = exp_pop;
            if (exp_pop) begin
                m_wr_addr = m_pops; m_wr_data = fifo_q[0]; m_pops++;
            end
            case (m_mode)
                0: if (start) begin m_mode = 1; m_pops = 0; end
                1: if (m_pops == N) m_mode = 2;
                2: m_mode = 3;
                default: m_mode = 0;
            endcase
        end
        @(posedge clk); #1; cyc++;
        if (popped && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic run_frame(input string nm);
        int seen = done_cyc_log.size();
        for (int i = 0; i < 60; i++) begin
            step();
            start = 1'b0;
            if (done_cyc_log.size() > seen) break;
        end
        chk({nm, "_finished"}, 32'(done_cyc_log.size() > seen), 32'd1);
        step();
    endtask

    initial begin
        // reset held with start high
        reset = 1'b0; start = 1'b1;
        fifo_q.push_back(8'hAA);
        step(); step();
        chk("rst_pop", 32'(pop), 0); chk("rst_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(mem_addr), 0); chk("rst_data", 32'(mem_data), 0);
        fifo_q.delete();
        reset = 1'b1; start = 1'b0;
        step();

        // plain frame, FIFO never empty
        clear_logs();
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h10 + i));
        start = 1'b1;
        run_frame("basic");
        chk("basic_nwr", 32'(wr_addr_log.size()), 6);
        for (int i = 0; i < 6 && i < wr_addr_log.size(); i++) begin
            chk("basic_addr", 32'(wr_addr_log[i]), 32'(i));
            chk("basic_data", 32'(wr_data_log[i]), 32'(8'h10 + i));
        end
        if (wr_cyc_log.size() == 6 && done_cyc_log.size() == 1) begin
            chk("basic_back2back", 32'(wr_cyc_log[5] - wr_cyc_log[0]), 5);
            chk("basic_done_lat",  32'(done_cyc_log[0] - wr_cyc_log[5]), 1);
        end else chk("basic_logs", 0, 1);
        chk("basic_busy_after", 32'(busy), 0);

        // FIFO runs dry after two pixels for three cycles
        clear_logs();
        fifo_q.push_back(8'h20); fifo_q.push_back(8'h21);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20 && dut_pops < 2; i++) step();
        step();
        repeat (3) step();
        chk("stall_pops", 32'(dut_pops), 2);
        chk("stall_nwr",  32'(wr_addr_log.size()), 2);
        for (int i = 2; i < 6; i++) fifo_q.push_back(8'(8'h20 + i));
        run_frame("stall");
        chk("stall_total", 32'(wr_addr_log.size()), 6);
        if (wr_addr_log.size() > 2) begin
            chk("stall_resume_addr", 32'(wr_addr_log[2]), 2);
            chk("stall_resume_data", 32'(wr_data_log[2]), 32'h22);
        end

        // FIFO holds more than a frame
        clear_logs();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h30 + i));
        start = 1'b1;
        run_frame("over");
        repeat (3) step();
        chk("over_pops", 32'(dut_pops), 6);
        chk("over_left", 32'(fifo_q.size()), 2);
        fifo_q.delete();

        // reset the cycle after the 4th pop
        clear_logs();
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h40 + i));
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20 && dut_pops < 4; i++) step();
        reset = 1'b0; step(); reset = 1'b1;
        chk("abort_we", 32'(mem_we), 0); chk("abort_addr", 32'(mem_addr), 0);
        chk("abort_data", 32'(mem_data), 0); chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0); chk("abort_pop", 32'(pop), 0);
        repeat (3) step();
        chk("abort_pops", 32'(dut_pops), 4);
        chk("abort_nwr",  32'(wr_addr_log.size()), 4);
        chk("abort_left", 32'(fifo_q.size()), 2);
        clear_logs();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h50 + i));
        start = 1'b1;
        run_frame("restart");
        chk("restart_nwr", 32'(wr_addr_log.size()), 6);
        if (wr_addr_log.size() > 0) begin
            chk("restart_addr0", 32'(wr_addr_log[0]), 0);
            chk("restart_data0", 32'(wr_data_log[0]), 32'h44);
        end

        // start held high: back-to-back frames
        clear_logs();
        for (int i = 0; i < 12; i++) fifo_q.push_back(8'($urandom));
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done_cyc_log.size() >= 2) break;
        end
        start = 1'b0;
        step();
        chk("b2b_frames", 32'(done_cyc_log.size()), 2);
        if (done_cyc_log.size() >= 1 && pop_cyc_log.size() >= 7)
            chk("b2b_gap", 32'(pop_cyc_log[6] - done_cyc_log[0]), 2);
        else chk("b2b_logs", 0, 1);
        fifo_q.delete();

        // randomized traffic, stray starts and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if (fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
            force_empty = ($urandom_range(0, 3) == 0);
            start       = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 16, as the output image memory address width.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8, as the pixel width.
REQ-003 The block SHALL take parameter ROW, default 256, as the image rows per frame.
REQ-004 The block SHALL take parameter COL, default 256, as the image columns per row.
REQ-005 The block SHALL have port clk, input, 1 bit, as the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit, a frame-write request, sampled in IDLE only.
REQ-008 The block SHALL have port fifo_empty, input, 1 bit, the filtered-pixel FIFO empty flag.
REQ-009 The block SHALL have port fifo_data, input, DATA_WIDTH bits, the FIFO read data, valid the cycle after pop.
REQ-010 The block SHALL have port pop, output, 1 bit, the FIFO read strobe.
REQ-011 The block SHALL have port mem_we, output, 1 bit, the image RAM write enable.
REQ-012 The block SHALL have port mem_addr, output, ADDR_WIDTH bits, the image RAM write address.
REQ-013 The block SHALL have port mem_data, output, DATA_WIDTH bits, the image RAM write data.
REQ-014 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-015 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last pixel write.

Function
REQ-016 The block SHALL implement states IDLE, RUN, DRAIN and FIN.
REQ-017 IDLE->RUN SHALL occur on start=1; pop-count, row and col counters clear to 0 on that edge.
REQ-018 In RUN, pop SHALL be asserted combinationally iff fifo_empty=0 and pop-count < ROW*COL.
REQ-019 A FIFO empty during RUN SHALL stall without error: no pop, no counter change.
REQ-020 Each pop SHALL increment pop-count; RUN->DRAIN SHALL occur on the cycle the (ROW*COL)-th pop is issued.
REQ-021 The cycle after any pop, mem_we SHALL be 1, mem_data SHALL equal fifo_data, and mem_addr SHALL equal row*COL+col, all registered.
REQ-022 After each write, col SHALL increment; at col=COL-1 it SHALL wrap to 0 and row SHALL increment.
REQ-023 DRAIN SHALL last exactly one cycle for the final write, then go to FIN.
REQ-024 FIN SHALL assert done for exactly one cycle, then go to IDLE.
REQ-025 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and FIN.
REQ-026 The total writes per frame SHALL be exactly ROW*COL, at addresses 0..ROW*COL-1 in ascending order with no gaps or repeats.
REQ-027 Maximum throughput SHALL be one pixel per cycle; pop-to-write latency SHALL be 1 cycle.
REQ-028 start asserted in RUN, DRAIN or FIN SHALL be ignored.
REQ-029 pop SHALL never be asserted while fifo_empty=1 or outside RUN.
REQ-030 Address arithmetic SHALL be computed at ADDR_WIDTH bits; ROW*COL ≤ 2^ADDR_WIDTH is a parameter constraint.

Reset
REQ-031 With reset=0 at a rising edge, the state SHALL go to IDLE, counters to 0, and mem_we, mem_addr, mem_data, busy and done to 0.
REQ-032 pop SHALL be 0 while reset=0.
REQ-033 Reset mid-frame SHALL abort the frame and discard any pending popped pixel (no write is issued); a new start is required.

Verification (ROW=2, COL=3)
REQ-034 The bench SHALL check this case: reset=0 for 2 cycles with start=1 -> pop=0, mem_we=0, busy=0, done=0.
REQ-035 The bench SHALL check this case: start pulse with FIFO holding 6 pixels 0x10..0x15, never empty -> 6 consecutive pops, writes at addresses 0..5 with data 0x10..0x15, done high 1 cycle after the addr-5 write, busy low afterwards.
REQ-036 The bench SHALL check this case: fifo_empty=1 for 3 cycles after pixel 2 -> no pop and no write for those cycles, then resume at address 2, total writes = 6.
REQ-037 The bench SHALL check this case: FIFO holding 8 pixels -> exactly 6 pops, and pop=0 from the cycle the state leaves RUN; 2 pixels remain in the FIFO.
REQ-038 The bench SHALL check this case: reset=0 on the cycle after the 4th pop -> no write for pixel 4, all outputs 0, start required again, and the next frame restarts at address 0.
REQ-039 The bench SHALL check this case: start=1 held continuously -> frames back-to-back, with one IDLE cycle between done and the next first pop.
